// File: rtl/perceptron_pkg.sv
// rtl/perceptron_pkg.sv - perceptron trainer state encoding, target codes and saturating helpers
package perceptron_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_SUM,
    ST_CHECK,
    ST_UPDATE,
    ST_DONE
  } state_e;

  localparam logic [1:0] T_POS = 2'b01;
  localparam logic [1:0] T_NEG = 2'b11;

  // Wide scratch type: holds any W_W x aligned-x product without overflow.
  localparam int ACC_W = 48;
  typedef logic signed [ACC_W-1:0] acc_t;

  function automatic acc_t sat_add(input acc_t a, input acc_t b, input int w);
    acc_t s;
    acc_t hi;
    acc_t lo;
    acc_t r;
    s  = a + b;
    hi = (acc_t'(1) <<< (w - 1)) - acc_t'(1);
    lo = -hi - acc_t'(1);
    if (s > hi) begin
      r = hi;
    end else if (s < lo) begin
      r = lo;
    end else begin
      r = s;
    end
    return r;
  endfunction

  function automatic acc_t align_x(input acc_t x, input int sh);
    return x <<< sh;
  endfunction

endpackage

// File: rtl/perceptron_mac.sv
// rtl/perceptron_mac.sv - combinational acc + ((coef * x) >>> FRAC) with saturation to W_W bits
module perceptron_mac
  import perceptron_pkg::*;
#(
  parameter int W_W  = 14,
  parameter int XA_W = 9,
  parameter int FRAC = 6
) (
  input  logic signed [W_W-1:0]  acc_i,
  input  logic signed [W_W-1:0]  coef_i,
  input  logic signed [XA_W-1:0] x_i,
  output logic signed [W_W-1:0]  sum_o
);

  acc_t acc_e;
  acc_t coef_e;
  acc_t x_e;
  acc_t prod;

  assign acc_e  = {{(ACC_W-W_W){acc_i[W_W-1]}}, acc_i};
  assign coef_e = {{(ACC_W-W_W){coef_i[W_W-1]}}, coef_i};
  assign x_e    = {{(ACC_W-XA_W){x_i[XA_W-1]}}, x_i};
  assign prod   = coef_e * x_e;

  // Arithmetic shift floors toward minus infinity before the saturating add.
  assign sum_o  = W_W'(sat_add(acc_e, prod >>> FRAC, W_W));

endmodule

// File: rtl/perceptron_trainer_n.sv
// rtl/perceptron_trainer_n.sv - perceptron training engine with streaming samples and one MAC per cycle
module perceptron_trainer_n
  import perceptron_pkg::*;
#(
  parameter int                 N_IN      = 2,
  parameter int                 X_W       = 7,
  parameter int                 X_FRAC    = 4,
  parameter int                 W_W       = 14,
  parameter int                 FRAC      = 6,
  parameter logic signed [W_W-1:0] ALPHA  = 14'sd24,
  parameter int                 MAX_EPOCH = 16,
  localparam int                EP_W      = $clog2(MAX_EPOCH + 1)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic                  train_en_i,
  input  logic                  s_valid_i,
  output logic                  s_ready_o,
  input  logic [N_IN*X_W-1:0]   s_x_i,
  input  logic [1:0]            s_t_i,
  input  logic                  s_last_i,
  output logic [N_IN*W_W-1:0]   w_flat_o,
  output logic [W_W-1:0]        b_o,
  output logic                  y_valid_o,
  output logic [1:0]            y_sign_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  converged_o,
  output logic [EP_W-1:0]       epoch_cnt_o
);

  localparam int XA_RAW = X_W + FRAC - X_FRAC;
  localparam int XA_W   = (XA_RAW > FRAC + 2) ? XA_RAW : FRAC + 2;
  localparam int STEP_W = $clog2(N_IN + 1);
  localparam logic signed [XA_W-1:0] X_ONE = XA_W'(1 << FRAC);

  state_e state_q, state_d;

  logic signed [W_W-1:0]  w_q [N_IN];
  logic signed [W_W-1:0]  b_q;
  logic signed [W_W-1:0]  yin_q;
  logic signed [X_W-1:0]  x_q [N_IN];
  logic signed [XA_W-1:0] x_al [N_IN];
  logic                   t_neg_q;
  logic                   last_q;
  logic                   train_q;
  logic                   upd_q;
  logic                   done_q;
  logic                   conv_q;
  logic [STEP_W-1:0]      step_q;
  logic [EP_W-1:0]        epoch_q;

  logic signed [W_W-1:0]  alpha_t;
  logic signed [W_W-1:0]  mac_acc;
  logic signed [W_W-1:0]  mac_coef;
  logic signed [XA_W-1:0] mac_x;
  logic signed [W_W-1:0]  mac_sum;
  acc_t                   x_ext;

  logic last_step;
  logic err;
  logic upd_eff;
  logic epoch_hit;
  logic sample_end;
  logic epoch_end;
  logic finish;

  assign last_step  = (step_q == STEP_W'(N_IN));
  assign err        = (yin_q == '0) | (yin_q[W_W-1] ^ t_neg_q);
  assign alpha_t    = t_neg_q ? -ALPHA : ALPHA;
  assign upd_eff    = upd_q | (state_q == ST_UPDATE);
  assign epoch_hit  = ((32'(epoch_q) + 1) == MAX_EPOCH);
  assign sample_end = ((state_q == ST_CHECK) && !(train_q && err)) ||
                      ((state_q == ST_UPDATE) && last_step);
  assign epoch_end  = sample_end && last_q;
  assign finish     = last_q && (!train_q || !upd_eff || epoch_hit);

  always_comb begin
    x_ext = '0;
    for (int i = 0; i < N_IN; i++) begin
      x_ext   = {{(ACC_W-X_W){x_q[i][X_W-1]}}, x_q[i]};
      x_al[i] = XA_W'(align_x(x_ext, FRAC - X_FRAC));
    end
  end

  // Step 0 addresses the bias; feeding x = 1.0 lets the same MAC do plain adds.
  always_comb begin
    mac_coef = (state_q == ST_SUM) ? b_q : alpha_t;
    mac_x    = X_ONE;
    mac_acc  = (state_q == ST_SUM) ? yin_q : b_q;
    for (int i = 0; i < N_IN; i++) begin
      if (step_q == STEP_W'(i + 1)) begin
        mac_coef = (state_q == ST_SUM) ? w_q[i] : alpha_t;
        mac_x    = x_al[i];
        mac_acc  = (state_q == ST_SUM) ? yin_q : w_q[i];
      end
    end
  end

  perceptron_mac #(
    .W_W  (W_W),
    .XA_W (XA_W),
    .FRAC (FRAC)
  ) u_mac (
    .acc_i  (mac_acc),
    .coef_i (mac_coef),
    .x_i    (mac_x),
    .sum_o  (mac_sum)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_DONE: if (start_i) state_d = ST_WAIT;
      ST_WAIT:          if (s_valid_i) state_d = ST_SUM;
      ST_SUM:           if (last_step) state_d = ST_CHECK;
      ST_CHECK: begin
        if (train_q && err) begin
          state_d = ST_UPDATE;
        end else begin
          state_d = finish ? ST_DONE : ST_WAIT;
        end
      end
      ST_UPDATE:        if (last_step) state_d = finish ? ST_DONE : ST_WAIT;
      default:          state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    s_ready_o = (state_q == ST_WAIT);
    y_valid_o = (state_q == ST_CHECK);
    y_sign_o  = yin_q[W_W-1] ? T_NEG : T_POS;
    busy_o    = (state_q != ST_IDLE) && (state_q != ST_DONE);
    w_flat_o  = '0;
    for (int i = 0; i < N_IN; i++) begin
      w_flat_o[i*W_W +: W_W] = w_q[i];
    end
  end

  assign b_o         = b_q;
  assign done_o      = done_q;
  assign converged_o = conv_q;
  assign epoch_cnt_o = epoch_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < N_IN; i++) begin
        w_q[i] <= '0;
        x_q[i] <= '0;
      end
      b_q     <= '0;
      yin_q   <= '0;
      t_neg_q <= 1'b0;
      last_q  <= 1'b0;
      train_q <= 1'b0;
      upd_q   <= 1'b0;
      done_q  <= 1'b0;
      conv_q  <= 1'b0;
      step_q  <= '0;
      epoch_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start_i) begin
            for (int i = 0; i < N_IN; i++) begin
              w_q[i] <= '0;
            end
            b_q     <= '0;
            epoch_q <= '0;
            upd_q   <= 1'b0;
            done_q  <= 1'b0;
            conv_q  <= 1'b0;
            train_q <= train_en_i;
          end
        end
        ST_WAIT: begin
          if (s_valid_i) begin
            for (int i = 0; i < N_IN; i++) begin
              x_q[i] <= s_x_i[i*X_W +: X_W];
            end
            t_neg_q <= (s_t_i == T_NEG);
            last_q  <= s_last_i;
            yin_q   <= '0;
            step_q  <= '0;
          end
        end
        ST_SUM: begin
          yin_q  <= mac_sum;
          step_q <= last_step ? '0 : step_q + 1'b1;
        end
        ST_UPDATE: begin
          upd_q <= 1'b1;
          if (step_q == '0) b_q <= mac_sum;
          for (int i = 0; i < N_IN; i++) begin
            if (step_q == STEP_W'(i + 1)) w_q[i] <= mac_sum;
          end
          step_q <= last_step ? '0 : step_q + 1'b1;
        end
        default: ;
      endcase
      // Placed after the case so clearing upd_q at an epoch boundary wins over UPDATE setting it.
      if (epoch_end) begin
        epoch_q <= epoch_q + 1'b1;
        if (finish) begin
          done_q <= 1'b1;
          conv_q <= train_q && !upd_eff;
        end else begin
          upd_q <= 1'b0;
        end
      end
    end
  end

endmodule
